// File: rtl/rb_param_bank.sv
// Parametrised register bank: shadow/active config, W1C sticky status with irq masking, 1-cycle read path.
// Read data and read_valid arrive one cycle after the access; there is no backpressure.
module rb_param_bank #(
  parameter int ADR_BITS = 8,
  parameter int NUM_CFG  = 8,
  parameter int NUM_STS  = 4,
  parameter int CTRL_ADR = 63,
  parameter int STS_BASE = 64,
  parameter int MSK_BASE = 96,
  parameter logic [NUM_CFG*8-1:0] CFG_RESET = '0
) (
  input  logic                  clk,
  input  logic                  resetb,
  input  logic [ADR_BITS-1:0]   address,
  input  logic [7:0]            data_write_in,
  input  logic                  reg_en,
  input  logic                  write_en,
  output logic [7:0]            data_read_out,
  output logic                  read_valid,
  output logic [NUM_CFG*8-1:0]  cfg_out,
  output logic                  cfg_update,
  input  logic [NUM_STS*8-1:0]  sts_set,
  output logic                  irq
);

  logic [7:0]         shadow [NUM_CFG];
  logic [7:0]         sticky [NUM_STS];
  logic [7:0]         mask   [NUM_STS];
  logic               auto_commit;
  logic               err;

  logic [31:0]        adr_ext;
  logic [NUM_CFG-1:0] hit_cfg;
  logic [NUM_STS-1:0] hit_sts;
  logic [NUM_STS-1:0] hit_msk;
  logic               hit_ctrl;
  logic               mapped;
  logic               rd;
  logic               wr;
  logic [7:0]         rd_dat;
  logic               pend;

  assign adr_ext  = 32'(address);
  assign hit_ctrl = (adr_ext == 32'(CTRL_ADR));
  assign mapped   = (|hit_cfg) | hit_ctrl | (|hit_sts) | (|hit_msk);
  assign rd       = reg_en & ~write_en;
  assign wr       = reg_en & write_en;

  always_comb begin
    hit_cfg = '0;
    hit_sts = '0;
    hit_msk = '0;
    for (int i = 0; i < NUM_CFG; i++) hit_cfg[i] = (adr_ext == 32'(i));
    for (int j = 0; j < NUM_STS; j++) begin
      hit_sts[j] = (adr_ext == 32'(STS_BASE + j));
      hit_msk[j] = (adr_ext == 32'(MSK_BASE + j));
    end
  end

  // Unmapped addresses fall through to zero.
  always_comb begin
    rd_dat = 8'h00;
    for (int i = 0; i < NUM_CFG; i++) if (hit_cfg[i]) rd_dat = shadow[i];
    if (hit_ctrl) rd_dat = {5'b0, err, auto_commit, 1'b0};
    for (int j = 0; j < NUM_STS; j++) begin
      if (hit_sts[j]) rd_dat = sticky[j];
      if (hit_msk[j]) rd_dat = mask[j];
    end
  end

  always_comb begin
    pend = 1'b0;
    for (int j = 0; j < NUM_STS; j++) pend = pend | (|(sticky[j] & mask[j]));
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      for (int i = 0; i < NUM_CFG; i++) shadow[i] <= CFG_RESET[8*i +: 8];
      for (int j = 0; j < NUM_STS; j++) begin
        sticky[j] <= 8'h00;
        mask[j]   <= 8'h00;
      end
      cfg_out       <= CFG_RESET;
      cfg_update    <= 1'b0;
      auto_commit   <= 1'b0;
      err           <= 1'b0;
      data_read_out <= 8'h00;
      read_valid    <= 1'b0;
      irq           <= 1'b0;
    end else begin
      read_valid <= rd;
      if (rd) data_read_out <= rd_dat;
      cfg_update <= 1'b0;
      irq        <= pend;

      for (int i = 0; i < NUM_CFG; i++) begin
        if (wr && hit_cfg[i]) begin
          shadow[i] <= data_write_in;
          if (auto_commit) begin
            cfg_out[8*i +: 8] <= data_write_in;
            cfg_update        <= 1'b1;
          end
        end
      end

      // Commit copies the pre-edge shadow; CTRL never aliases a config address.
      if (wr && hit_ctrl) begin
        auto_commit <= data_write_in[1];
        if (data_write_in[0]) begin
          for (int i = 0; i < NUM_CFG; i++) cfg_out[8*i +: 8] <= shadow[i];
          cfg_update <= 1'b1;
        end
      end

      if (reg_en && !mapped)                     err <= 1'b1;
      else if (wr && hit_ctrl && data_write_in[2]) err <= 1'b0;

      for (int j = 0; j < NUM_STS; j++) begin
        sticky[j] <= (sticky[j] & ~((wr && hit_sts[j]) ? data_write_in : 8'h00))
                   | sts_set[8*j +: 8];
        if (wr && hit_msk[j]) mask[j] <= data_write_in;
      end
    end
  end

endmodule

// File: tb/tb_rb_param_bank.sv
// Bench for rb_param_bank: directed scenarios plus random accesses against an array-based register model.
module tb_rb_param_bank;
  localparam int NUM_CFG  = 8;
  localparam int NUM_STS  = 4;
  localparam int CTRL_ADR = 63;
  localparam int STS_BASE = 64;
  localparam int MSK_BASE = 96;
  localparam logic [63:0] CFG_RST = 64'h0000_0000_0000_0285;

  logic        clk = 1'b0;
  logic        resetb;
  logic [7:0]  address;
  logic [7:0]  data_write_in;
  logic        reg_en;
  logic        write_en;
  logic [7:0]  data_read_out;
  logic        read_valid;
  logic [63:0] cfg_out;
  logic        cfg_update;
  logic [31:0] sts_set;
  logic        irq;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_shadow [NUM_CFG];
  logic [7:0] m_active [NUM_CFG];
  logic [7:0] m_sticky [NUM_STS];
  logic [7:0] m_mask   [NUM_STS];
  bit         m_auto, m_err;
  bit         exp_rv, exp_upd, exp_irq;
  logic [7:0] exp_rd;

  rb_param_bank #(
    .ADR_BITS(8), .NUM_CFG(NUM_CFG), .NUM_STS(NUM_STS), .CTRL_ADR(CTRL_ADR),
    .STS_BASE(STS_BASE), .MSK_BASE(MSK_BASE), .CFG_RESET(CFG_RST)
  ) dut (
    .clk(clk), .resetb(resetb), .address(address), .data_write_in(data_write_in),
    .reg_en(reg_en), .write_en(write_en), .data_read_out(data_read_out),
    .read_valid(read_valid), .cfg_out(cfg_out), .cfg_update(cfg_update),
    .sts_set(sts_set), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  task automatic model_reset();
    logic [63:0] rv;
    rv = CFG_RST;
    for (int i = 0; i < NUM_CFG; i++) begin
      m_shadow[i] = rv[8*i +: 8];
      m_active[i] = rv[8*i +: 8];
    end
    for (int j = 0; j < NUM_STS; j++) begin
      m_sticky[j] = 8'h00;
      m_mask[j]   = 8'h00;
    end
    m_auto = 0; m_err = 0;
    exp_rv = 0; exp_upd = 0; exp_irq = 0; exp_rd = 8'h00;
  endtask

  function automatic bit model_mapped(int adr);
    return (adr < NUM_CFG) || (adr == CTRL_ADR) ||
           (adr >= STS_BASE && adr < STS_BASE + NUM_STS) ||
           (adr >= MSK_BASE && adr < MSK_BASE + NUM_STS);
  endfunction

  function automatic logic [7:0] model_read(int adr);
    if (adr < NUM_CFG) return m_shadow[adr];
    if (adr == CTRL_ADR) return {5'b0, m_err, m_auto, 1'b0};
    if (adr >= STS_BASE && adr < STS_BASE + NUM_STS) return m_sticky[adr - STS_BASE];
    if (adr >= MSK_BASE && adr < MSK_BASE + NUM_STS) return m_mask[adr - MSK_BASE];
    return 8'h00;
  endfunction

  function automatic logic [63:0] model_cfg();
    logic [63:0] v;
    for (int i = 0; i < NUM_CFG; i++) v[8*i +: 8] = m_active[i];
    return v;
  endfunction

  // One access cycle: drive, advance the model with pre-edge state, then step past the edge.
  task automatic cycle(input bit en, input bit we, input int adr, input logic [7:0] d,
                       input logic [31:0] sts);
    bit rd, wr, nirq;
    logic [7:0] clr;
    reg_en = en; write_en = we; address = adr[7:0]; data_write_in = d; sts_set = sts;
    rd = en && !we;
    wr = en && we;
    nirq = 0;
    for (int j = 0; j < NUM_STS; j++) if ((m_sticky[j] & m_mask[j]) != 8'h00) nirq = 1;
    if (rd) exp_rd = model_read(adr);
    exp_rv = rd;
    exp_upd = 0;
    if (en && !model_mapped(adr)) m_err = 1;
    if (wr) begin
      if (adr < NUM_CFG) begin
        m_shadow[adr] = d;
        if (m_auto) begin m_active[adr] = d; exp_upd = 1; end
      end else if (adr == CTRL_ADR) begin
        if (d[0]) begin m_active = m_shadow; exp_upd = 1; end
        m_auto = d[1];
        if (d[2]) m_err = 0;
      end else if (adr >= MSK_BASE && adr < MSK_BASE + NUM_STS) begin
        m_mask[adr - MSK_BASE] = d;
      end
    end
    for (int j = 0; j < NUM_STS; j++) begin
      clr = (wr && adr == STS_BASE + j) ? d : 8'h00;
      m_sticky[j] = (m_sticky[j] & ~clr) | sts[8*j +: 8];
    end
    exp_irq = nirq;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetb = 0; reg_en = 0; write_en = 0; address = 0; data_write_in = 0; sts_set = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetb = 1;
    checks++; if (cfg_out !== CFG_RST) begin errors++; $display("FAIL reset_cfg_out: got %h want %h", cfg_out, CFG_RST); end
    checks++; if ({read_valid, cfg_update, irq, data_read_out} !== 11'h0) begin errors++;
      $display("FAIL reset_outputs: rv=%b upd=%b irq=%b rd=%h want all 0", read_valid, cfg_update, irq, data_read_out); end
    cycle(1, 0, 0, 8'h00, 0);
    checks++; if (read_valid !== 1'b1 || data_read_out !== 8'h85) begin errors++;
      $display("FAIL reset_read0: rv=%b rd=%h want 1/85", read_valid, data_read_out); end
    cycle(1, 0, 1, 8'h00, 0);
    checks++; if (read_valid !== 1'b1 || data_read_out !== 8'h02) begin errors++;
      $display("FAIL reset_read1: rv=%b rd=%h want 1/02", read_valid, data_read_out); end
    cycle(0, 0, 0, 8'h00, 0);
    checks++; if (read_valid !== 1'b0 || data_read_out !== 8'h02) begin errors++;
      $display("FAIL idle_hold: rv=%b rd=%h want 0/02", read_valid, data_read_out); end
  endtask

  task automatic test_commit();
    cycle(1, 1, 1, 8'h3C, 0);
    checks++; if (cfg_out[15:8] !== 8'h02 || cfg_update !== 1'b0) begin errors++;
      $display("FAIL shadow_only: cfg[15:8]=%h upd=%b want 02/0", cfg_out[15:8], cfg_update); end
    cycle(1, 0, 1, 8'h00, 0);
    checks++; if (data_read_out !== 8'h3C) begin errors++; $display("FAIL shadow_readback: got %h want 3c", data_read_out); end
    cycle(1, 1, CTRL_ADR, 8'h01, 0);
    checks++; if (cfg_out !== model_cfg() || cfg_out[15:8] !== 8'h3C || cfg_update !== 1'b1) begin errors++;
      $display("FAIL commit: cfg=%h upd=%b want %h/1", cfg_out, cfg_update, model_cfg()); end
    cycle(1, 0, CTRL_ADR, 8'h00, 0);
    checks++; if (cfg_update !== 1'b0) begin errors++; $display("FAIL commit_pulse: upd=%b want 0", cfg_update); end
    cycle(0, 0, 0, 8'h00, 0);
    checks++; if (data_read_out !== 8'h00) begin errors++; $display("FAIL ctrl_selfclear: got %h want 00", data_read_out); end
  endtask

  task automatic test_auto_commit();
    cycle(1, 1, CTRL_ADR, 8'h02, 0);
    cycle(1, 1, 3, 8'hA5, 0);
    checks++; if (cfg_out[31:24] !== 8'hA5 || cfg_update !== 1'b1 || cfg_out !== model_cfg()) begin errors++;
      $display("FAIL auto_commit: cfg=%h upd=%b want %h/1", cfg_out, cfg_update, model_cfg()); end
    cycle(1, 1, 3, 8'hA5, 0);
    checks++; if (cfg_update !== 1'b1) begin errors++; $display("FAIL auto_same_data: upd=%b want 1", cfg_update); end
    cycle(0, 0, 0, 8'h00, 0);
    checks++; if (cfg_update !== 1'b0) begin errors++; $display("FAIL auto_pulse_end: upd=%b want 0", cfg_update); end
  endtask

  task automatic test_status_irq();
    cycle(1, 1, MSK_BASE, 8'h01, 0);
    cycle(0, 0, 0, 8'h00, 32'h1);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_early: irq=%b want 0", irq); end
    cycle(1, 0, STS_BASE, 8'h00, 0);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_rise: irq=%b want 1", irq); end
    cycle(1, 1, STS_BASE, 8'h01, 0);
    checks++; if (data_read_out !== 8'h01) begin errors++; $display("FAIL sts_read: got %h want 01", data_read_out); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_hold_after_clr: irq=%b want 1", irq); end
    cycle(0, 0, 0, 8'h00, 0);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_fall: irq=%b want 0", irq); end
    cycle(1, 1, STS_BASE, 8'h01, 32'h1);
    cycle(1, 0, STS_BASE, 8'h00, 0);
    checks++; if (data_read_out !== 8'h01 || data_read_out !== exp_rd) begin errors++;
      $display("FAIL set_wins: got %h want 01", data_read_out); end
    // Read coinciding with a set returns the pre-set value.
    cycle(1, 1, STS_BASE, 8'h01, 0);
    cycle(1, 0, STS_BASE + 1, 8'h00, 32'h0000_8000);
    checks++; if (data_read_out !== 8'h00) begin errors++; $display("FAIL read_preset: got %h want 00", data_read_out); end
    cycle(1, 0, STS_BASE + 1, 8'h00, 0);
    checks++; if (data_read_out !== 8'h80) begin errors++; $display("FAIL read_postset: got %h want 80", data_read_out); end
  endtask

  task automatic test_unmapped();
    cycle(1, 1, CTRL_ADR, 8'h00, 0);
    cycle(1, 0, 8'h50, 8'h00, 0);
    checks++; if (read_valid !== 1'b1 || data_read_out !== 8'h00) begin errors++;
      $display("FAIL unmapped_read: rv=%b rd=%h want 1/00", read_valid, data_read_out); end
    cycle(1, 0, CTRL_ADR, 8'h00, 0);
    cycle(1, 1, CTRL_ADR, 8'h04, 0);
    checks++; if (data_read_out !== 8'h04) begin errors++; $display("FAIL err_set: ctrl=%h want 04", data_read_out); end
    cycle(1, 0, CTRL_ADR, 8'h00, 0);
    cycle(0, 0, 0, 8'h00, 0);
    checks++; if (data_read_out !== 8'h00) begin errors++; $display("FAIL err_clear: ctrl=%h want 00", data_read_out); end
    cycle(1, 1, 8'hC8, 8'hFF, 0);
    cycle(1, 0, CTRL_ADR, 8'h00, 0);
    checks++; if (data_read_out !== 8'h04 || cfg_out !== model_cfg()) begin errors++;
      $display("FAIL unmapped_write: ctrl=%h cfg=%h want 04/%h", data_read_out, cfg_out, model_cfg()); end
  endtask

  task automatic test_random();
    int adr;
    bit we;
    logic [31:0] sts;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 5))
        0, 5: adr = $urandom_range(0, NUM_CFG - 1);
        1: adr = CTRL_ADR;
        2: adr = STS_BASE + $urandom_range(0, NUM_STS - 1);
        3: adr = MSK_BASE + $urandom_range(0, NUM_STS - 1);
        default: adr = ($urandom_range(0, 1) == 0) ? $urandom_range(8, 62) : $urandom_range(100, 255);
      endcase
      we = $urandom_range(0, 1);
      sts = $urandom & $urandom & $urandom;
      cycle($urandom_range(0, 3) != 0, we, adr, 8'($urandom), sts);
      checks++; if (read_valid !== exp_rv) begin errors++; $display("FAIL rnd_rv n=%0d: got %b want %b", n, read_valid, exp_rv); end
      checks++; if (data_read_out !== exp_rd) begin errors++; $display("FAIL rnd_rd n=%0d: got %h want %h", n, data_read_out, exp_rd); end
      checks++; if (cfg_out !== model_cfg()) begin errors++; $display("FAIL rnd_cfg n=%0d: got %h want %h", n, cfg_out, model_cfg()); end
      checks++; if (cfg_update !== exp_upd) begin errors++; $display("FAIL rnd_upd n=%0d: got %b want %b", n, cfg_update, exp_upd); end
      checks++; if (irq !== exp_irq) begin errors++; $display("FAIL rnd_irq n=%0d: got %b want %b", n, irq, exp_irq); end
    end
  endtask

  task automatic test_reset_mid();
    cycle(1, 1, CTRL_ADR, 8'h00, 0);
    cycle(1, 1, 2, 8'h77, 0);
    cycle(1, 1, CTRL_ADR, 8'h01, 0);
    cycle(1, 1, MSK_BASE + 2, 8'hFF, 32'h0010_0000);
    cycle(1, 0, 2, 8'h00, 0);
    cycle(1, 0, 3, 8'h00, 0);
    checks++; if (irq !== 1'b1 || read_valid !== 1'b1) begin errors++;
      $display("FAIL pre_reset_state: irq=%b rv=%b want 1/1", irq, read_valid); end
    #2 resetb = 0;
    #1;
    checks++; if (cfg_out !== CFG_RST || {read_valid, cfg_update, irq, data_read_out} !== 11'h0) begin errors++;
      $display("FAIL async_reset: cfg=%h rv=%b upd=%b irq=%b rd=%h", cfg_out, read_valid, cfg_update, irq, data_read_out); end
    @(posedge clk); #1;
    checks++; if (read_valid !== 1'b0) begin errors++; $display("FAIL reset_no_rv: rv=%b want 0", read_valid); end
    reg_en = 0;
    @(negedge clk);
    resetb = 1;
    model_reset();
    cycle(1, 0, STS_BASE + 2, 8'h00, 0);
    cycle(1, 0, 0, 8'h00, 0);
    checks++; if (data_read_out !== 8'h85 || irq !== 1'b0) begin errors++;
      $display("FAIL post_reset: rd=%h irq=%b want 85/0", data_read_out, irq); end
  endtask

  initial begin
    test_reset();
    test_commit();
    test_auto_commit();
    test_status_irq();
    test_unmapped();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rb_param_bank.md
# rb_param_bank

Parametrised register bank with shadow/active configuration registers, sticky write-1-to-clear status registers with per-bit interrupt masking, and a qualified read path with a valid strobe. It sits between the serial/host register-access front end (address, data, reg_en, write_en) and the datapath blocks (system and DSP configuration consumers, event sources). It replaces fixed, hand-written banks: register count, base addresses and reset values are all set by parameters.

## Interface
- ADR_BITS, 8, address width
- NUM_CFG, 8, number of 8-bit config registers at addresses 0..NUM_CFG-1 (1..32)
- NUM_STS, 4, number of 8-bit status registers (1..16)
- CTRL_ADR, 63, address of control register; must be ≥ NUM_CFG
- STS_BASE, 64, status j at STS_BASE+j
- MSK_BASE, 96, mask j at MSK_BASE+j; ranges must not overlap
- CFG_RESET, all zero, NUM_CFG*8-bit reset value; register i = bits [8i+7:8i]

Ports:
- clk  in  1  clock; all state changes on rising edge
- resetb  in  1  reset; asynchronous and active-low
- address  in  ADR_BITS  register address
- data_write_in  in  8  write data
- reg_en  in  1  access strobe; one access per cycle where high
- write_en  in  1  1 = write, 0 = read (qualified by reg_en)
- data_read_out  out  8  registered read data
- read_valid  out  1  one-cycle pulse, data_read_out valid
- cfg_out  out  NUM_CFG*8  active config; register i at [8i+7:8i]
- cfg_update  out  1  one-cycle pulse when cfg_out was loaded
- sts_set  in  NUM_STS*8  hardware event bits, level, sampled each cycle
- irq  out  1  registered OR of (sticky & mask)

## Operation
- Write = reg_en & write_en; read = reg_en & ~write_en. No action when reg_en = 0.
- Config: write to i < NUM_CFG loads shadow[i]. Reads return shadow[i].
- Control register at CTRL_ADR:
  - bit0 commit: write 1 loads all active ← shadow. Self-clearing; reads 0.
  - bit1 auto_commit: RW. When 1, a config write loads shadow[i] and active[i] at the same edge.
  - bit2 err: sticky; W1C. Reads return err.
  - bits[7:3]: read 0.
- Commit uses shadow values before the edge. cfg_update pulses on every commit edge and every auto-commit write, including when the data is unchanged.
- Status j: sticky[j] ← (sticky[j] & ~wmask) | sts_set[j]. wmask = data_write_in on a write to STS_BASE+j, otherwise 0. Set wins over clear on the same bit in the same cycle.
- Mask j: RW, reset 0.
- irq ← |(sticky & mask) over all status registers, registered.
- Unmapped address, read or write: err ← 1. A write has no other effect. A read returns 8'h00 with read_valid.
- Read: data_read_out ← the selected value as of before the edge; read_valid ← 1. With no read, read_valid ← 0 and data_read_out holds its value.
- A read of a status register in the same cycle as sts_set returns the pre-set value. The set is visible on the next read.

## Timing
- Reset (asynchronous, resetb = 0):
  - shadow = active = CFG_RESET; cfg_out = CFG_RESET.
  - sticky, mask, auto_commit, err = 0.
  - data_read_out = 0; read_valid, cfg_update, irq = 0.
- Read latency is 1: access in cycle N gives data and read_valid in cycle N+1. Back-to-back reads give read_valid high continuously.
- Write takes effect at the edge ending the access cycle. A read of the same address in cycle N+1 returns the new value.
- Commit or auto-commit write in cycle N: cfg_out changes and cfg_update is high in cycle N+1 only.
- sts_set high in cycle N: sticky set in N+1. If masked in, irq is high from N+2.
- A W1C clear in cycle N drops irq from N+2, provided no other masked sticky bit is set and sts_set is low.
- resetb asserted mid-operation: all state returns to reset values immediately. A pending read_valid or cfg_update is dropped. Release is synchronised externally.

## Test plan
- Reset with CFG_RESET = 0x...0285: cfg_out = CFG_RESET. Read addr 0 → 0x85, read addr 1 → 0x02, each with read_valid one cycle after the access.
- Write 0x3C to addr 1 with auto_commit = 0: cfg_out[15:8] is unchanged and readback = 0x3C. Write CTRL = 0x01: cfg_out[15:8] = 0x3C next cycle, cfg_update is a single pulse, CTRL reads 0x00.
- Write CTRL = 0x02, then write 0xA5 to addr 3: cfg_out[31:24] = 0xA5 and cfg_update pulses in the cycle after the write.
- MSK_BASE = 0x01, pulse sts_set[0] for 1 cycle: status 0 reads 0x01 and irq rises 2 cycles after the pulse. Write 0x01 to STS_BASE: irq falls. Clear and set of bit 0 in the same cycle → bit stays 1.
- Read unmapped addr 0x50 → 0x00 with read_valid and err = 1 (CTRL reads 0x04). Write CTRL = 0x04 → err = 0.
- Assert resetb mid-burst after a committed config change and a set sticky bit: all outputs return to reset values asynchronously, with no further read_valid pulse.
